// File: rtl/ram_pkg.sv
// Shared types and helpers for the multiport RAM: FSM encoding, byte-lane width,
// byte-enable merge and per-byte even parity on words up to MAX_DW bits.
package ram_pkg;

  typedef enum logic [0:0] {ST_CLEAR, ST_READY} ram_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MAX_DW = 1024;
  localparam int unsigned MAX_BE = MAX_DW / BYTE_W;

  // Callers widen arguments with MAX_DW'() and truncate the result to their own width.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int b = 0; b < int'(MAX_BE); b++) begin
      if (be[b]) res[b*BYTE_W +: BYTE_W] = new_w[b*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  function automatic logic [MAX_BE-1:0] byte_parity(input logic [MAX_DW-1:0] word);
    logic [MAX_BE-1:0] par;
    par = '0;
    for (int b = 0; b < int'(MAX_BE); b++) begin
      par[b] = ^word[b*BYTE_W +: BYTE_W];
    end
    return par;
  endfunction

endpackage

// File: rtl/multiport_ram_if.sv
// Request/response bundle of the 1-write / NRD-read RAM.
interface multiport_ram_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 12,
  parameter int unsigned NRD       = 2
);
  logic                     wen;
  logic [DATAWIDTH/8-1:0]   wbe;
  logic [ADDRWIDTH-1:0]     wAddr;
  logic [DATAWIDTH-1:0]     wData;
  logic [NRD-1:0]           ren;
  logic [NRD*ADDRWIDTH-1:0] rAddr;
  logic [NRD*DATAWIDTH-1:0] rData;
  logic [NRD-1:0]           rValid;
  logic                     busy;
  logic [NRD-1:0]           perr;

  modport master (
    output wen, wbe, wAddr, wData, ren, rAddr,
    input  rData, rValid, busy, perr
  );

  modport slave (
    input  wen, wbe, wAddr, wData, ren, rAddr,
    output rData, rValid, busy, perr
  );
endinterface

// File: rtl/mp_ram_bank.sv
// Storage array: one byte-enabled write port and NRD combinational read taps.
// With MULTIPORT_RAM_PARITY_EN defined a parity bit per byte is stored alongside.
module mp_ram_bank #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned MEM_NUM   = 4096,
  parameter int unsigned NRD       = 2,
  parameter int unsigned IW        = 12,
  parameter int unsigned BE_W      = DATAWIDTH / 8
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [IW-1:0]                   waddr,
  input  logic [DATAWIDTH-1:0]            wdata,
  input  logic [BE_W-1:0]                 wbe,
  input  logic [NRD-1:0][IW-1:0]          raddr,
`ifdef MULTIPORT_RAM_PARITY_EN
  input  logic [BE_W-1:0]                 wpar,
  output logic [NRD-1:0][BE_W-1:0]        rpar,
`endif
  output logic [NRD-1:0][DATAWIDTH-1:0]   rdata
);

  logic [DATAWIDTH-1:0] mem [MEM_NUM];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(NRD); i++) rdata[i] = mem[raddr[i]];
  end

`ifdef MULTIPORT_RAM_PARITY_EN
  logic [BE_W-1:0] par [MEM_NUM];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (wbe[b]) par[waddr][b] <= wpar[b];
      end
    end
  end

  always_comb begin
    rpar = '0;
    for (int i = 0; i < int'(NRD); i++) rpar[i] = par[raddr[i]];
  end
`endif

endmodule

// File: rtl/multiport_ram.sv
// 1-write / NRD-read RAM with write-first forwarding, registered reads and a post-reset
// clear sequencer. Optional per-byte parity: define MULTIPORT_RAM_PARITY_EN.
module multiport_ram
  import ram_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned ADDRWIDTH  = 12,
  parameter int unsigned MEM_NUM    = 4096,
  parameter int unsigned NRD        = 2,
  parameter int unsigned INIT_CLEAR = 1
) (
  input logic           clk,
  input logic           rst,
  multiport_ram_if.slave bus
);

  localparam int unsigned BE_W = DATAWIDTH / BYTE_W;
  localparam int unsigned IW   = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam logic [ADDRWIDTH:0] MEM_LIMIT = (ADDRWIDTH + 1)'(MEM_NUM);
  localparam logic [IW-1:0]      LAST_IDX  = IW'(MEM_NUM - 1);

  ram_state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: ;
      default: state_d = ST_READY;
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign bus.busy = busy;

  // Bank write port: clear sequencer owns it while busy.
  logic                 bank_we;
  logic [IW-1:0]        bank_waddr;
  logic [DATAWIDTH-1:0] bank_wdata;
  logic [BE_W-1:0]      bank_wbe;
  logic                 wr_in_range;

  always_comb begin
    wr_in_range = ({1'b0, bus.wAddr} < MEM_LIMIT);
    if (busy) begin
      bank_we    = ~rst;
      bank_waddr = cnt_q;
      bank_wdata = '0;
      bank_wbe   = '1;
    end else begin
      bank_we    = bus.wen & wr_in_range & ~rst;
      bank_waddr = bus.wAddr[IW-1:0];
      bank_wdata = bus.wData;
      bank_wbe   = bus.wbe;
    end
  end

  logic [NRD-1:0][IW-1:0]        bank_raddr;
  logic [NRD-1:0][DATAWIDTH-1:0] bank_rdata;
  logic [NRD-1:0][ADDRWIDTH-1:0] rd_addr;
  logic [NRD-1:0][DATAWIDTH-1:0] rd_word;
  logic [NRD-1:0]                rd_in_range;
  logic [NRD-1:0]                rd_fwd;
  logic [NRD-1:0]                rd_fire;

`ifdef MULTIPORT_RAM_PARITY_EN
  logic [BE_W-1:0]           bank_wpar;
  logic [NRD-1:0][BE_W-1:0]  bank_rpar;
  logic [NRD-1:0]            rd_perr;
  logic [BE_W-1:0]           fwd_be;

  assign bank_wpar = BE_W'(byte_parity(MAX_DW'(bank_wdata)));
`endif

  mp_ram_bank #(
    .DATAWIDTH (DATAWIDTH),
    .MEM_NUM   (MEM_NUM),
    .NRD       (NRD),
    .IW        (IW),
    .BE_W      (BE_W)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .wbe   (bank_wbe),
    .raddr (bank_raddr),
`ifdef MULTIPORT_RAM_PARITY_EN
    .wpar  (bank_wpar),
    .rpar  (bank_rpar),
`endif
    .rdata (bank_rdata)
  );

  always_comb begin
    bank_raddr  = '0;
    rd_addr     = '0;
    rd_word     = '0;
    rd_in_range = '0;
    rd_fwd      = '0;
    rd_fire     = '0;
`ifdef MULTIPORT_RAM_PARITY_EN
    rd_perr     = '0;
    fwd_be      = '0;
`endif
    for (int i = 0; i < int'(NRD); i++) begin
      rd_addr[i]     = bus.rAddr[i*ADDRWIDTH +: ADDRWIDTH];
      bank_raddr[i]  = rd_addr[i][IW-1:0];
      rd_in_range[i] = ({1'b0, rd_addr[i]} < MEM_LIMIT);
      rd_fwd[i]      = bus.wen && (bus.wAddr == rd_addr[i]);
      rd_fire[i]     = bus.ren[i] & ~busy;
      if (!rd_in_range[i]) begin
        rd_word[i] = '0;
      end else if (rd_fwd[i]) begin
        rd_word[i] = DATAWIDTH'(byte_merge(MAX_DW'(bank_rdata[i]), MAX_DW'(bus.wData),
                                           MAX_BE'(bus.wbe)));
      end else begin
        rd_word[i] = bank_rdata[i];
      end
`ifdef MULTIPORT_RAM_PARITY_EN
      // Forwarded lanes carry fresh parity, so only stored lanes are checked.
      fwd_be     = rd_fwd[i] ? bus.wbe : '0;
      rd_perr[i] = rd_in_range[i] &&
                   |((bank_rpar[i] ^ BE_W'(byte_parity(MAX_DW'(bank_rdata[i])))) & ~fwd_be);
`endif
    end
  end

  logic [NRD-1:0][DATAWIDTH-1:0] rdata_q;
  logic [NRD-1:0]                rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rd_fire;
      for (int i = 0; i < int'(NRD); i++) begin
        if (rd_fire[i]) rdata_q[i] <= rd_word[i];
      end
    end
  end

  assign bus.rData  = rdata_q;
  assign bus.rValid = rvalid_q;

`ifdef MULTIPORT_RAM_PARITY_EN
  logic [NRD-1:0] perr_q;

  always_ff @(posedge clk) begin
    if (rst) perr_q <= '0;
    else     perr_q <= rd_fire & rd_perr;
  end

  assign bus.perr = perr_q;
`else
  assign bus.perr = '0;
`endif

endmodule

// File: tb/tb_multiport_ram.sv
// Directed, table-driven bench for multiport_ram (MEM_NUM=16, two read ports).
module tb_multiport_ram;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned MN = 16;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multiport_ram_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .NRD(NR)) bus ();

  multiport_ram #(
    .DATAWIDTH  (DW),
    .ADDRWIDTH  (AW),
    .MEM_NUM    (MN),
    .NRD        (NR),
    .INIT_CLEAR (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wen;
    logic [3:0]  wbe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  ren;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  exp_valid;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.wen   = 1'b0;
    bus.wbe   = '0;
    bus.wAddr = '0;
    bus.wData = '0;
    bus.ren   = '0;
    bus.rAddr = '0;
  endtask

  // Counts cycles until busy falls, with ren asserted to confirm reads are ignored.
  task automatic wait_clear(input string tag);
    int n;
    logic seen_valid;
    n = 0;
    seen_valid = 1'b0;
    bus.ren   = 2'b11;
    bus.rAddr = {5'd1, 5'd2};
    while (bus.busy && n < 200) begin
      step();
      n++;
      if (bus.rValid != 2'b00) seen_valid = 1'b1;
    end
    chk({tag, "_len"}, 64'(n), 64'd16);
    chk({tag, "_rvalid_while_busy"}, 64'(seen_valid), 64'd0);
    bus.ren = '0;
  endtask

  initial begin
    vecs[0]  = '{"w5_full",     1, 4'hF, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,
                 2'b00, 32'h0, 32'h0};
    vecs[1]  = '{"w5_low",      1, 4'h3, 5'd5,  32'h00001122, 2'b00, 5'd0,  5'd0,
                 2'b00, 32'h0, 32'h0};
    vecs[2]  = '{"r5",          0, 4'h0, 5'd0,  32'h0,        2'b01, 5'd5,  5'd0,
                 2'b01, 32'hDEAD1122, 32'h0};
    vecs[3]  = '{"w7_ones",     1, 4'hF, 5'd7,  32'h11111111, 2'b00, 5'd0,  5'd0,
                 2'b00, 32'hDEAD1122, 32'h0};
    vecs[4]  = '{"fwd7_both",   1, 4'hC, 5'd7,  32'hA5A5A5A5, 2'b11, 5'd7,  5'd7,
                 2'b11, 32'hA5A51111, 32'hA5A51111};
    vecs[5]  = '{"r7_r5",       0, 4'h0, 5'd0,  32'h0,        2'b11, 5'd7,  5'd5,
                 2'b11, 32'hA5A51111, 32'hDEAD1122};
    vecs[6]  = '{"oor_w20_r20", 1, 4'hF, 5'd20, 32'hFFFFFFFF, 2'b11, 5'd20, 5'd4,
                 2'b11, 32'h0, 32'h0};
    vecs[7]  = '{"r4_alias",    0, 4'h0, 5'd0,  32'h0,        2'b10, 5'd0,  5'd4,
                 2'b10, 32'h0, 32'h0};
    vecs[8]  = '{"wbe0_fwd",    1, 4'h0, 5'd9,  32'hFFFFFFFF, 2'b01, 5'd9,  5'd0,
                 2'b01, 32'h0, 32'h0};
    vecs[9]  = '{"w9_b0_fwd",   1, 4'h1, 5'd9,  32'h000000AB, 2'b11, 5'd9,  5'd5,
                 2'b11, 32'h000000AB, 32'hDEAD1122};
    vecs[10] = '{"hold",        0, 4'h0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0,
                 2'b00, 32'h000000AB, 32'hDEAD1122};
    vecs[11] = '{"w15_fwd_p1",  1, 4'hF, 5'd15, 32'h12345678, 2'b10, 5'd0,  5'd15,
                 2'b10, 32'h000000AB, 32'h12345678};
    vecs[12] = '{"r15_p0",      0, 4'h0, 5'd0,  32'h0,        2'b01, 5'd15, 5'd0,
                 2'b01, 32'h12345678, 32'h12345678};

    idle();
    rst = 1'b1;
    step();
    chk("reset_busy",   64'(bus.busy),   64'd1);
    chk("reset_rvalid", 64'(bus.rValid), 64'd0);
    chk("reset_rdata",  64'(bus.rData),  64'd0);
    chk("reset_perr",   64'(bus.perr),   64'd0);

    rst = 1'b0;
    wait_clear("clear");

    for (int a = 0; a < int'(MN); a++) begin
      bus.ren   = 2'b11;
      bus.rAddr = {5'(15 - a), 5'(a)};
      step();
      chk($sformatf("clear_rd_valid_%0d", a), 64'(bus.rValid), 64'd3);
      chk($sformatf("clear_rd_data_%0d", a), 64'(bus.rData), 64'd0);
    end
    idle();

    for (int v = 0; v < 13; v++) begin
      bus.wen   = vecs[v].wen;
      bus.wbe   = vecs[v].wbe;
      bus.wAddr = vecs[v].waddr;
      bus.wData = vecs[v].wdata;
      bus.ren   = vecs[v].ren;
      bus.rAddr = {vecs[v].ra1, vecs[v].ra0};
      step();
      chk({vecs[v].name, "_valid"}, 64'(bus.rValid),       64'(vecs[v].exp_valid));
      chk({vecs[v].name, "_d0"},    64'(bus.rData[31:0]),  64'(vecs[v].exp_d0));
      chk({vecs[v].name, "_d1"},    64'(bus.rData[63:32]), 64'(vecs[v].exp_d1));
      chk({vecs[v].name, "_perr"},  64'(bus.perr),         64'd0);
    end
    idle();

    // Reset partway through the clear restarts the full sweep.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("midclear_busy_at8", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear("reclear");

    bus.ren   = 2'b01;
    bus.rAddr = {5'd0, 5'd5};
    step();
    chk("reclear_r5_valid", 64'(bus.rValid),      64'd1);
    chk("reclear_r5_data",  64'(bus.rData[31:0]), 64'd0);
    idle();

`ifdef MULTIPORT_RAM_PARITY_EN
    bus.wen   = 1'b1;
    bus.wbe   = 4'hF;
    bus.wAddr = 5'd3;
    bus.wData = 32'h0F0F0F0F;
    step();
    idle();
    dut.u_bank.mem[3] = dut.u_bank.mem[3] ^ 32'h1;
    bus.ren   = 2'b01;
    bus.rAddr = {5'd0, 5'd3};
    step();
    chk("par_flip_valid", 64'(bus.rValid), 64'd1);
    chk("par_flip_perr",  64'(bus.perr),   64'd1);
    bus.ren   = 2'b00;
    bus.wen   = 1'b1;
    bus.wbe   = 4'hF;
    bus.wAddr = 5'd3;
    bus.wData = 32'h0F0F0F0F;
    step();
    idle();
    bus.ren   = 2'b01;
    bus.rAddr = {5'd0, 5'd3};
    step();
    chk("par_rewrite_perr", 64'(bus.perr),         64'd0);
    chk("par_rewrite_data", 64'(bus.rData[31:0]), 64'h0F0F0F0F);
    idle();
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
